// File: rtl/pipelined_barrel_shifter.sv
// Pipelined four-mode barrel shifter: the shift is split into binary levels spread
// over `stages` register stages, with a valid/ready handshake and a global stall.
module pipelined_barrel_shifter #(
  parameter int width  = 32,
  parameter int stages = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [width-1:0]           i_bits,
  input  logic [$clog2(width)-1:0]   i_shift,
  input  logic [1:0]                 i_mode,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [width-1:0]           o_bits
);

  localparam int levels    = $clog2(width);
  localparam int per_stage = (levels + stages - 1) / stages;

  if (width < 2 || (width & (width - 1)) != 0) begin : bad_width
    $error("pipelined_barrel_shifter: width must be a power of two >= 2");
  end
  if (stages < 1 || stages > levels) begin : bad_stages
    $error("pipelined_barrel_shifter: stages must be in 1..clog2(width)");
  end

  logic en;

  assign en      = !o_valid || o_ready;
  assign i_ready = en;

  // One level of the shift; arithmetic fill uses the sign captured at entry.
  function automatic logic [width-1:0] shift_level(input logic [width-1:0] d,
                                                   input int              amt,
                                                   input logic [1:0]      mode,
                                                   input logic            sign);
    case (mode)
      2'd0:    shift_level = d >> amt;
      2'd1:    shift_level = sign ? ~((~d) >> amt) : (d >> amt);
      2'd2:    shift_level = d << amt;
      default: shift_level = (d >> amt) | (d << (width - amt));
    endcase
  endfunction

  for (genvar s = 0; s < stages; s++) begin : stg
    localparam int lo = s * per_stage;
    localparam int hi = (lo + per_stage > levels) ? levels : lo + per_stage;

    logic [width-1:0]  din;
    logic [width-1:0]  dnext;
    logic [width-1:0]  dq;
    logic [levels-1:0] sin;
    logic [1:0]        mode_in;
    logic              sign_in;
    logic              vin;
    logic              vq;

    if (s == 0) begin : src
      assign din     = i_bits;
      assign sin     = i_shift;
      assign mode_in = i_mode;
      assign sign_in = i_bits[width-1];
      assign vin     = i_valid;
    end else begin : src
      assign din     = stg[s-1].dq;
      assign sin     = stg[s-1].carry.sq;
      assign mode_in = stg[s-1].carry.mq;
      assign sign_in = stg[s-1].carry.gq;
      assign vin     = stg[s-1].vq;
    end

    // This stage applies levels lo..hi-1, LSB levels first.
    always_comb begin
      dnext = din;
      for (int k = lo; k < hi; k++) begin
        if (sin[k]) dnext = shift_level(dnext, 1 << k, mode_in, sign_in);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vq <= 1'b0;
        dq <= '0;
      end else if (en) begin
        vq <= vin;
        dq <= dnext;
      end
    end

    // Shift amount, mode and sign ride along for the stages still to come.
    if (s < stages - 1) begin : carry
      logic [levels-1:0] sq;
      logic [1:0]        mq;
      logic              gq;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sq <= '0;
          mq <= '0;
          gq <= 1'b0;
        end else if (en) begin
          sq <= sin;
          mq <= mode_in;
          gq <= sign_in;
        end
      end
    end
  end

  assign o_valid = stg[stages-1].vq;
  assign o_bits  = stg[stages-1].dq;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (width=8, stages=3): an arithmetic
// reference model feeds a scoreboard, plus directed literal vectors.
module tb_pipelined_barrel_shifter;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_bits;
  logic [2:0] i_shift;
  logic [1:0] i_mode;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] o_bits;

  int         checks;
  int         fails;
  int         run;
  int         max_run;
  int         out_count;
  logic       prev_stall;
  logic [7:0] prev_bits;
  logic [7:0] expq[$];

  pipelined_barrel_shifter #(.width(8), .stages(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_bits(i_bits), .i_shift(i_shift), .i_mode(i_mode),
    .o_valid(o_valid), .o_ready(o_ready), .o_bits(o_bits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result from plain integer arithmetic.
  function automatic logic [7:0] model(input logic [7:0] b, input logic [2:0] s, input logic [1:0] m);
    int v;
    int sb;
    int ub;
    ub = int'(b);
    sb = b[7] ? ub - 256 : ub;
    case (m)
      2'd0:    v = ub >> s;
      2'd1:    v = (sb >>> s) & 255;
      2'd2:    v = (ub << s) & 255;
      default: v = ((ub >> s) | (ub << (8 - s))) & 255;
    endcase
    return v[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until the DUT accepts it; returns just after the capture edge.
  task automatic applyStimulus(input logic [7:0] b, input logic [2:0] s, input logic [1:0] m);
    int n;
    i_valid = 1'b1;
    i_bits  = b;
    i_shift = s;
    i_mode  = m;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (i_ready) break;
    end
    if (n == 50) checkOutput("accept_timeout", {31'd0, i_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic runBeat(input logic [7:0] b, input logic [2:0] s, input logic [1:0] m,
                         input logic [7:0] exp, input string name);
    int n;
    checkOutput({"model_", name}, model(b, s, m), exp);
    applyStimulus(b, s, m);
    for (n = 0; n < 10; n++) begin
      if (o_valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_valid"}, {31'd0, o_valid}, 32'd1);
    checkOutput(name, o_bits, exp);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compares every meaningful output cycle and records accepted inputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        if (expq.size() == 0) begin
          checkOutput("spurious_valid", {31'd0, o_valid}, 32'd0);
        end else begin
          checkOutput("scoreboard", o_bits, expq[0]);
          if (o_ready) begin
            void'(expq.pop_front());
            out_count++;
          end
        end
        if (prev_stall) checkOutput("stall_stable", o_bits, prev_bits);
      end
      prev_stall = o_valid && !o_ready;
      prev_bits  = o_bits;
      run        = o_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (i_valid && i_ready) expq.push_back(model(i_bits, i_shift, i_mode));
    end else begin
      prev_stall = 1'b0;
      run        = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] held;
    int         base;
    int         n;
    checks     = 0;
    fails      = 0;
    run        = 0;
    max_run    = 0;
    out_count  = 0;
    prev_stall = 1'b0;
    prev_bits  = '0;
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_bits     = '0;
    i_shift    = '0;
    i_mode     = '0;
    o_ready    = 1'b1;
    #1;
    checkOutput("reset_o_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset_o_bits", o_bits, 32'h0);
    checkOutput("reset_i_ready", {31'd0, i_ready}, 32'd1);
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: capture edge, then o_valid on the third edge counting that one.
    applyStimulus(8'hB4, 3'd2, 2'd0);
    checkOutput("lat_edge1", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge2", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge3", {31'd0, o_valid}, 32'd1);
    checkOutput("lsr_b4_2", o_bits, 32'h2D);
    checkOutput("model_lsr_b4_2", model(8'hB4, 3'd2, 2'd0), 32'h2D);
    @(posedge clk);
    #1;
    checkOutput("single_beat_gone", {31'd0, o_valid}, 32'd0);

    runBeat(8'hB4, 3'd3, 2'd1, 8'hF6, "asr_b4_3");
    runBeat(8'h74, 3'd3, 2'd1, 8'h0E, "asr_74_3");
    runBeat(8'hB4, 3'd3, 2'd2, 8'hA0, "lsl_b4_3");
    runBeat(8'hB4, 3'd3, 2'd3, 8'h96, "ror_b4_3");
    runBeat(8'hB4, 3'd0, 2'd0, 8'hB4, "zero_lsr");
    runBeat(8'hB4, 3'd0, 2'd1, 8'hB4, "zero_asr");
    runBeat(8'hB4, 3'd0, 2'd2, 8'hB4, "zero_lsl");
    runBeat(8'hB4, 3'd0, 2'd3, 8'hB4, "zero_ror");
    runBeat(8'h81, 3'd7, 2'd1, 8'hFF, "asr_max");
    runBeat(8'h81, 3'd7, 2'd3, 8'h03, "ror_max");

    // Back-to-back stream of 8 beats with no gaps.
    max_run = 0;
    base    = out_count;
    for (int i = 0; i < 8; i++) applyStimulus(8'h11 * i + 8'h0F, 3'(i), 2'(i));
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stream_run", max_run, 32'd8);
    checkOutput("stream_count", out_count - base, 32'd8);

    // Fill the pipe under backpressure, stall 5 cycles, then release.
    o_ready = 1'b0;
    base    = out_count;
    applyStimulus(8'hC3, 3'd1, 2'd0);
    applyStimulus(8'hC3, 3'd2, 2'd1);
    applyStimulus(8'hC3, 3'd5, 2'd3);
    held = o_bits;
    checkOutput("stall_full", {31'd0, o_valid}, 32'd1);
    fork
      applyStimulus(8'h5A, 3'd4, 2'd2);
      begin
        repeat (5) begin
          @(posedge clk);
          #1;
          checkOutput("stall_i_ready", {31'd0, i_ready}, 32'd0);
          checkOutput("stall_hold", o_bits, held);
        end
        o_ready = 1'b1;
      end
    join
    for (n = 0; n < 20 && expq.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stall_drain", expq.size(), 32'd0);
    checkOutput("stall_count", out_count - base, 32'd4);

    // Reset with two beats in flight.
    applyStimulus(8'hF0, 3'd1, 2'd0);
    applyStimulus(8'hF0, 3'd2, 2'd0);
    rst_n = 1'b0;
    expq.delete();
    #1;
    checkOutput("midreset_o_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("midreset_o_bits", o_bits, 32'h0);
    #2 rst_n = 1'b1;
    base = out_count;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("post_reset_idle", {31'd0, o_valid}, 32'd0);
    end
    runBeat(8'h81, 3'd1, 2'd1, 8'hC0, "post_reset_asr");
    checkOutput("post_reset_count", out_count - base, 32'd1);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("final_empty", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the combinational right shifter.
- Supports four shift modes: logical right, arithmetic right, logical left, rotate right.
- Data moves through a configurable number of register stages under a valid/ready handshake with backpressure.
- Sits on datapaths needing shifts at clock rates a single-level combinational shifter cannot meet.

Parameters:
- width, 32, data width in bits; must be a power of two, >= 2 (elaboration error otherwise).
- stages, 2, pipeline register stages, 1..clog2(width) (elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  block accepts input this cycle.
- i_bits  in  width  data to shift.
- i_shift  in  clog2(width)  shift amount, 0..width-1.
- i_mode  in  2  mode: 0 = logical right, 1 = arithmetic right, 2 = logical left, 3 = rotate right.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts output.
- o_bits  out  width  shifted result.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release):
  - all stage valid flags = 0, so o_valid = 0.
  - o_bits = 0; all stage data/shift/mode registers = 0.
  - i_ready follows its combinational definition (= 1 while o_valid = 0).
- Pipeline enable: en = !o_valid || o_ready; i_ready = en.
  - All stages advance together when en = 1 and hold when en = 0 (global stall).
  - Input transfer occurs when i_valid && i_ready.
  - Output transfer occurs when o_valid && o_ready.
- Latency: exactly `stages` cycles from accepted input to o_valid, absent stalls.
  - Throughput: 1 beat/cycle while o_ready = 1.
  - Bubbles are not collapsed: an empty slot advances like data.
- Level decomposition: the shift is split into L = clog2(width) binary levels; level k shifts by 2^k when i_shift[k] = 1.
  - Levels are assigned to stages in order, LSB levels first.
  - Stage s gets ceil(L/stages) levels until the levels run out; the final stage may get fewer.
  - Each stage carries its remaining shift bits and mode forward in registers.
- Mode semantics at each level:
  - Logical right: zero fill from the MSB side.
  - Arithmetic right: fill with bit width-1 of the original input. The sign bit is captured at entry and carried down the pipeline, not re-read from intermediate data.
  - Logical left: zero fill from the LSB side.
  - Rotate right: bits leaving the LSB side re-enter at the MSB side.
- Shift of 0 passes data unchanged in every mode.
- A shift of width-1 is the maximum; larger values are unrepresentable.
- Stall boundary:
  - While o_valid = 1 and o_ready = 0, o_bits and every stage register hold stable.
  - i_ready = 0 and input is ignored.
- Simultaneous: output consumed and new input accepted in the same cycle when o_ready = 1.
- Reset mid-operation flushes every in-flight beat; no partial outputs after rst_n releases.
- i_shift/i_mode are sampled only on an input transfer.

Test Plan:
- width=8, stages=3, o_ready=1; i_bits=0xB4, shift=2, mode=0 -> o_bits=0x2D, o_valid exactly 3 cycles after acceptance.
- mode=1, i_bits=0xB4, shift=3 -> 0xF6; i_bits=0x74, shift=3 -> 0x0E.
- mode=2, i_bits=0xB4, shift=3 -> 0xA0; mode=3, i_bits=0xB4, shift=3 -> 0x96; shift=0 in all four modes -> 0xB4.
- Back-to-back stream of 8 beats, o_ready=1 -> 8 consecutive o_valid cycles, order preserved, no gaps.
- Hold o_ready=0 for 5 cycles with the pipe full -> i_ready=0, o_bits stable, no beat lost or duplicated after release.
- Assert rst_n low mid-stream with 2 beats in flight -> o_valid=0 and o_bits=0 immediately; the first output after release comes from a post-reset input.
